// File: rtl/bt_uart_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart_bridge_if
// Description : Bundles the byte-stream, handshake, sequencer and display
//               signals exchanged between bt_uart_bridge and its surroundings.
//               Signal names keep their pin-level i_/o_ names as seen from the
//               bridge.
//   slave  modport : the bridge's view (i_* inputs, o_* outputs)
//   master modport : the environment's view (drives i_*, observes o_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface bt_uart_bridge_if;
    // Computer -> BT channel
    logic       i_Comp_RX_DV;
    logic [7:0] i_Comp_RX_Byte;
    logic       o_BT_TX_DV;
    logic [7:0] o_BT_TX_Byte;
    logic       i_BT_TX_Done;
    // BT -> computer channel
    logic       i_BT_RX_DV;
    logic [7:0] i_BT_RX_Byte;
    logic       o_Comp_TX_DV;
    logic [7:0] o_Comp_TX_Byte;
    logic       i_Comp_TX_Done;
    // RN4871 sequencer
    logic       i_BT_Reset_Req;
    logic       o_BT_Rst_L;
    logic       o_BT_Ready;
    // Display and status
    logic       i_Disp_Sel;
    logic [7:0] o_Disp_Byte;
    logic       o_Ovf_C2B;
    logic       o_Ovf_B2C;

    modport slave (
        input  i_Comp_RX_DV, i_Comp_RX_Byte, i_BT_TX_Done,
        input  i_BT_RX_DV, i_BT_RX_Byte, i_Comp_TX_Done,
        input  i_BT_Reset_Req, i_Disp_Sel,
        output o_BT_TX_DV, o_BT_TX_Byte, o_Comp_TX_DV, o_Comp_TX_Byte,
        output o_BT_Rst_L, o_BT_Ready, o_Disp_Byte, o_Ovf_C2B, o_Ovf_B2C
    );

    modport master (
        output i_Comp_RX_DV, i_Comp_RX_Byte, i_BT_TX_Done,
        output i_BT_RX_DV, i_BT_RX_Byte, i_Comp_TX_Done,
        output i_BT_Reset_Req, i_Disp_Sel,
        input  o_BT_TX_DV, o_BT_TX_Byte, o_Comp_TX_DV, o_Comp_TX_Byte,
        input  o_BT_Rst_L, o_BT_Ready, o_Disp_Byte, o_Ovf_C2B, o_Ovf_B2C
    );
endinterface
`default_nettype wire

// File: rtl/bt_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart_bridge
// Description : Buffered byte bridge between the computer UART and the RN4871
//               Bluetooth UART. Two independent FIFO channels (C2B, B2C) with a
//               launch/done drain handshake, an RN4871 reset/boot sequencer
//               that gates C2B draining, a last-byte display register and
//               sticky per-channel overflow flags.
// Ports       : i_Clk   - main clock
//               i_Rst_L - asynchronous active-low reset
//               bus     - bt_uart_bridge_if.slave (UART strobes/bytes,
//                         TX done strobes, reset request, display select,
//                         sequencer status, display byte, overflow flags)
// Revision    : 1.0 - initial release
// ============================================================================
module bt_uart_bridge #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int RST_CYCLES      = 25000,
    parameter int BOOT_CYCLES     = 2500000
) (
    input  wire logic       i_Clk,
    input  wire logic       i_Rst_L,
    bt_uart_bridge_if.slave bus
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int MAX_CYC = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    // ------------------------------------------------------------------
    // RN4871 reset/boot sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        SEQ_RST  = 2'd0,
        SEQ_BOOT = 2'd1,
        SEQ_RUN  = 2'd2
    } seq_t;

    seq_t             seq_state;
    seq_t             seq_next;
    logic [CNT_W-1:0] seq_cnt;
    logic [CNT_W-1:0] seq_cnt_next;
    logic             bt_rst_l;
    logic             bt_ready;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            seq_state <= SEQ_RST;
            seq_cnt   <= '0;
        end else begin
            seq_state <= seq_next;
            seq_cnt   <= seq_cnt_next;
        end
    end

    always_comb begin
        seq_next     = seq_state;
        seq_cnt_next = seq_cnt;
        bt_rst_l     = 1'b1;
        bt_ready     = 1'b0;

        case (seq_state)
            SEQ_RST: begin
                bt_rst_l = 1'b0;
                // The transition edge is the last of the RST_CYCLES edges
                // spent here, so the count stops one short of the parameter.
                if (seq_cnt == RST_LAST) begin
                    seq_next     = SEQ_BOOT;
                    seq_cnt_next = '0;
                end else begin
                    seq_cnt_next = seq_cnt + CNT_ONE;
                end
            end
            SEQ_BOOT: begin
                if (seq_cnt == BOOT_LAST) begin
                    seq_next     = SEQ_RUN;
                    seq_cnt_next = '0;
                end else begin
                    seq_cnt_next = seq_cnt + CNT_ONE;
                end
            end
            SEQ_RUN: begin
                bt_ready = 1'b1;
            end
            default: begin
                seq_next     = SEQ_RST;
                seq_cnt_next = '0;
            end
        endcase

        // A reset request overrides everything, including a request that
        // lands while already in SEQ_RST (restarts the hold time).
        if (bus.i_BT_Reset_Req) begin
            seq_next     = SEQ_RST;
            seq_cnt_next = '0;
        end
    end

    assign bus.o_BT_Rst_L = bt_rst_l;
    assign bus.o_BT_Ready = bt_ready;

    // ------------------------------------------------------------------
    // Channel plumbing: index 0 = C2B, index 1 = B2C
    // ------------------------------------------------------------------
    logic [1:0]      wr_dv;
    logic [1:0][7:0] wr_byte;
    logic [1:0]      tx_done;
    logic [1:0]      drain_en;
    logic [1:0]      tx_dv;
    logic [1:0][7:0] tx_byte;
    logic [1:0]      ovf;

    assign wr_dv    = {bus.i_BT_RX_DV, bus.i_Comp_RX_DV};
    assign wr_byte  = {bus.i_BT_RX_Byte, bus.i_Comp_RX_Byte};
    assign tx_done  = {bus.i_Comp_TX_Done, bus.i_BT_TX_Done};
    // Only the BT-bound channel waits for the module to finish booting.
    assign drain_en = {1'b1, bt_ready};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [7:0]       mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic             full;
        logic             empty;
        logic             pop;
        logic             idle;
        logic             dv_q;
        logic [7:0]       byte_q;
        logic             ovf_q;

        // Extra pointer MSB distinguishes full from empty when the
        // address bits coincide.
        assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
        assign empty = (wr_ptr == rd_ptr);
        assign pop   = idle && !empty && drain_en[ch];

        always_ff @(posedge i_Clk) begin
            if (wr_dv[ch] && !full) begin
                mem[wr_ptr[PTR_W-2:0]] <= wr_byte[ch];
            end
        end

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                idle   <= 1'b1;
                dv_q   <= 1'b0;
                byte_q <= 8'h00;
                ovf_q  <= 1'b0;
            end else begin
                // Fullness is judged before this edge, so a write that
                // coincides with a pop from a full FIFO is still dropped.
                if (wr_dv[ch]) begin
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                    end
                end

                dv_q <= pop;
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    byte_q <= mem[rd_ptr[PTR_W-2:0]];
                    idle   <= 1'b0;
                end else if (tx_done[ch]) begin
                    // pop requires idle, so this only matters while busy;
                    // a Done arriving while already idle changes nothing.
                    idle <= 1'b1;
                end
            end
        end

        assign tx_dv[ch]   = dv_q;
        assign tx_byte[ch] = byte_q;
        assign ovf[ch]     = ovf_q;
    end

    assign bus.o_BT_TX_DV     = tx_dv[0];
    assign bus.o_BT_TX_Byte   = tx_byte[0];
    assign bus.o_Comp_TX_DV   = tx_dv[1];
    assign bus.o_Comp_TX_Byte = tx_byte[1];
    assign bus.o_Ovf_C2B      = ovf[0];
    assign bus.o_Ovf_B2C      = ovf[1];

    // ------------------------------------------------------------------
    // Display: the launched byte is held until the next pop, so it doubles
    // as the per-channel last-byte register.
    // ------------------------------------------------------------------
    logic [7:0] disp_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            disp_q <= 8'h00;
        end else begin
            disp_q <= bus.i_Disp_Sel ? tx_byte[1] : tx_byte[0];
        end
    end

    assign bus.o_Disp_Byte = disp_q;

endmodule
`default_nettype wire
